// File: rtl/ffd_bank_arbiter.sv
// ffd_bank_arbiter
//   Round-robin arbiter and sequencer in front of a shared WIDTH-bit bank of
//   D flip-flop cells. Each of NREQ requesters posts a command (load, set all,
//   clear all, or the illegal code 11). One requester is granted at a time.
//   The block drives the bank strobes for exactly one cycle and then
//   acknowledges the requester. Sequence: IDLE -> ISSUE -> ACK -> IDLE, which
//   is one command every three cycles.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   req       in   [NREQ]        per-requester request level
//   op        in   [2*NREQ]      per-requester command, [2i+1:2i]
//                                00 load, 01 set all, 10 clear all, 11 illegal
//   wdata     in   [WIDTH*NREQ]  per-requester load data, [WIDTH*i +: WIDTH]
//   gnt       out  [NREQ]        one-hot grant, held through ISSUE and ACK
//   ack       out  [NREQ]        one-hot single-cycle acknowledge
//   err       out                pulses with ack when the granted op was 11
//   busy      out                high whenever the sequencer is not idle
//   bank_d    out  [WIDTH]       bank D data, zero unless bank_en is high
//   bank_en   out                bank load strobe
//   bank_set  out                bank set-all strobe
//   bank_clr  out                bank clear-all strobe
//
// All outputs are registered.
module ffd_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic                    busy,
    output logic [WIDTH-1:0]        bank_d,
    output logic                    bank_en,
    output logic                    bank_set,
    output logic                    bank_clr
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_ILL  = 2'b11
    } op_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    op_t                op_q, op_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   bank_d_q, bank_d_d;
    logic               bank_en_q, bank_en_d;
    logic               bank_set_q, bank_set_d;
    logic               bank_clr_q, bank_clr_d;

    // Per-requester views of the packed command and data buses.
    logic [1:0]         op_a   [NREQ];
    logic [WIDTH-1:0]   data_a [NREQ];

    logic               arb_hit;
    logic [PTR_W-1:0]   arb_idx;
    op_t                arb_op;
    logic [WIDTH-1:0]   arb_data;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_a[i]   = op[2*i +: 2];
            data_a[i] = wdata[WIDTH*i +: WIDTH];
        end
    end

    // Rotating priority search: candidates visited in order ptr, ptr+1, ...
    // modulo NREQ. The sum carries one extra bit so the wrap is exact for
    // NREQ values that are not a power of two.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_op   = OP_LOAD;
        arb_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] cand;
            sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end
            cand = sum[PTR_W-1:0];
            if (!arb_hit && req[cand]) begin
                arb_hit  = 1'b1;
                arb_idx  = cand;
                arb_op   = op_t'(op_a[cand]);
                arb_data = data_a[cand];
            end
        end
    end

    // State register together with all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            op_q       <= OP_LOAD;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            bank_d_q   <= '0;
            bank_en_q  <= 1'b0;
            bank_set_q <= 1'b0;
            bank_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            bank_d_q   <= bank_d_d;
            bank_en_q  <= bank_en_d;
            bank_set_q <= bank_set_d;
            bank_clr_q <= bank_clr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = arb_hit ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. Outputs are registered, so the values for a state are
    // computed here on the transition into it; the strobes therefore appear
    // in the same cycle as the grant.
    always_comb begin
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        op_d       = op_q;
        gnt_d      = '0;
        ack_d      = '0;
        err_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);
        bank_d_d   = '0;
        bank_en_d  = 1'b0;
        bank_set_d = 1'b0;
        bank_clr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    idx_d = arb_idx;
                    op_d  = arb_op;
                    gnt_d = NREQ'(1) << arb_idx;
                    case (arb_op)
                        OP_LOAD: begin
                            bank_en_d = 1'b1;
                            bank_d_d  = arb_data;
                        end
                        OP_SET:  bank_set_d = 1'b1;
                        OP_CLR:  bank_clr_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                gnt_d = gnt_q;
                ack_d = gnt_q;
                err_d = (op_q == OP_ILL);
            end
            S_ACK: begin
                ptr_d = (idx_q == PTR_W'(NREQ-1)) ? '0 : idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign bank_d   = bank_d_q;
    assign bank_en  = bank_en_q;
    assign bank_set = bank_set_q;
    assign bank_clr = bank_clr_q;

endmodule

// File: tb/tb_ffd_bank_arbiter.sv
// Testbench for ffd_bank_arbiter. A timeline reference model predicts every
// output after every rising edge: a command granted at edge g shows its grant
// and strobe after g, grant+ack after g+1, frees the pointer at g+2 and the
// next arbitration takes place at edge g+3.
module tb_ffd_bank_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int VW = 2*N + W + 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [2*N-1:0] op;
    logic [W*N-1:0] wdata;
    logic [N-1:0]   gnt, ack;
    logic           err, busy;
    logic [W-1:0]   bank_d;
    logic           bank_en, bank_set, bank_clr;

    ffd_bank_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op       (op),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .bank_d   (bank_d),
        .bank_en  (bank_en),
        .bank_set (bank_set),
        .bank_clr (bank_clr)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int             edge_n;
    int             g_edge;
    int             g_idx;
    logic [1:0]     g_op;
    logic [W-1:0]   g_data;
    int             rr;
    logic [N-1:0]   e_gnt, e_ack;
    logic           e_err, e_busy, e_en, e_set, e_clr;
    logic [W-1:0]   e_d;
    logic [VW-1:0]  exp_v;
    logic [VW-1:0]  obs_v;
    logic           drop_on_ack;

    assign obs_v = {gnt, ack, err, busy, bank_d, bank_en, bank_set, bank_clr};

    task automatic model_reset();
        edge_n = 0;
        g_edge = -10;
        g_idx  = 0;
        g_op   = 2'b00;
        g_data = '0;
        rr     = 0;
        e_gnt = '0; e_ack = '0; e_err = 1'b0; e_busy = 1'b0;
        e_en = 1'b0; e_set = 1'b0; e_clr = 1'b0; e_d = '0;
        exp_v  = '0;
    endtask

    task automatic tick();
        logic [N-1:0]   r;
        logic [2*N-1:0] o;
        logic [W*N-1:0] wd;
        @(posedge clk);
        r = req; o = op; wd = wdata;
        if (!reset) begin
            model_reset();
        end else begin
            edge_n++;
            if (edge_n >= g_edge + 3) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (rr + k) % N;
                    if (r[c] && g_edge != edge_n) begin
                        g_edge = edge_n;
                        g_idx  = c;
                        g_op   = o[2*c +: 2];
                        g_data = wd[W*c +: W];
                    end
                end
            end
            e_gnt = '0; e_ack = '0; e_err = 1'b0; e_busy = 1'b0;
            e_en = 1'b0; e_set = 1'b0; e_clr = 1'b0; e_d = '0;
            if (edge_n == g_edge) begin
                e_gnt[g_idx] = 1'b1;
                e_busy = 1'b1;
                e_en   = (g_op == 2'b00);
                e_d    = (g_op == 2'b00) ? g_data : '0;
                e_set  = (g_op == 2'b01);
                e_clr  = (g_op == 2'b10);
            end else if (edge_n == g_edge + 1) begin
                e_gnt[g_idx] = 1'b1;
                e_ack[g_idx] = 1'b1;
                e_err  = (g_op == 2'b11);
                e_busy = 1'b1;
            end else if (edge_n == g_edge + 2) begin
                rr = (g_idx + 1) % N;
            end
            exp_v = {e_gnt, e_ack, e_err, e_busy, e_d, e_en, e_set, e_clr};
        end
        @(negedge clk);
        if (drop_on_ack) req = req & ~e_ack;
    endtask

    task automatic rand_inputs();
        req = N'($urandom);
        for (int i = 0; i < N; i++) begin
            op[2*i +: 2]  = 2'($urandom);
            wdata[W*i +: W] = W'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; op = '0; wdata = '0; drop_on_ack = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_v !== '0) begin
            miscompares++;
            $display("FAIL reset_async got %h want %h", obs_v, {VW{1'b0}});
        end
        for (int n = 0; n < 6; n++) begin
            rand_inputs();
            tick();
            vectors++;
            if (obs_v !== '0) begin
                miscompares++;
                $display("FAIL reset_hold got %h want %h", obs_v, {VW{1'b0}});
            end
        end
        req = '0;
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_idle got %h want %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_single_load();
        rand_inputs();
        req = 4'b0001;
        op[1:0] = 2'b00;
        wdata[7:0] = 8'hA5;
        drop_on_ack = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL load_model cyc %0d got %h want %h", cyc, obs_v, exp_v);
            end
            if (cyc == 1) begin
                vectors++;
                if ({gnt, bank_en, bank_d} !== {4'b0001, 1'b1, 8'hA5}) begin
                    miscompares++;
                    $display("FAIL load_issue got %h want %h",
                             {gnt, bank_en, bank_d}, {4'b0001, 1'b1, 8'hA5});
                end
            end
            if (cyc == 2) begin
                vectors++;
                if ({ack, err, bank_en} !== {4'b0001, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL load_ack got %h want %h",
                             {ack, err, bank_en}, {4'b0001, 1'b0, 1'b0});
                end
            end
        end
    endtask

    task automatic test_set_clear();
        int set_cnt, clr_cnt, en_cnt;
        set_cnt = 0; clr_cnt = 0; en_cnt = 0;
        drop_on_ack = 1'b1;
        rand_inputs();
        req = 4'b0010;
        op[3:2] = 2'b01;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL set_model got %h want %h", obs_v, exp_v);
            end
            set_cnt += int'(bank_set);
            clr_cnt += int'(bank_clr);
            en_cnt  += int'(bank_en);
        end
        vectors++;
        if (set_cnt != 1 || clr_cnt != 0) begin
            miscompares++;
            $display("FAIL set_pulses got set=%0d clr=%0d want set=1 clr=0", set_cnt, clr_cnt);
        end
        rand_inputs();
        req = 4'b0100;
        op[5:4] = 2'b10;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL clr_model got %h want %h", obs_v, exp_v);
            end
            set_cnt += int'(bank_set);
            clr_cnt += int'(bank_clr);
            en_cnt  += int'(bank_en);
        end
        vectors++;
        if (set_cnt != 1 || clr_cnt != 1 || en_cnt != 0) begin
            miscompares++;
            $display("FAIL clr_pulses got set=%0d clr=%0d en=%0d want 1 1 0",
                     set_cnt, clr_cnt, en_cnt);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] prev;
        logic [N-1:0] order [$];
        int           at [$];
        logic [N-1:0] want [5];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
        want[3] = 4'b1000; want[4] = 4'b0001;
        reset = 1'b0;
        model_reset();
        rand_inputs();
        req = 4'b1111;
        drop_on_ack = 1'b0;
        tick();
        reset = 1'b1;
        prev = '0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL cont_model cyc %0d got %h want %h", cyc, obs_v, exp_v);
            end
            vectors++;
            if (!$onehot0(gnt)) begin
                miscompares++;
                $display("FAIL cont_onehot got %b want one-hot or zero", gnt);
            end
            if (gnt != '0 && gnt != prev) begin
                order.push_back(gnt);
                at.push_back(cyc);
            end
            prev = gnt;
        end
        vectors++;
        if (order.size() < 5) begin
            miscompares++;
            $display("FAIL cont_count got %0d grants want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (order[i] !== want[i] || at[i] != 1 + 3*i) begin
                    miscompares++;
                    $display("FAIL cont_order[%0d] got %b@%0d want %b@%0d",
                             i, order[i], at[i], want[i], 1 + 3*i);
                end
            end
        end
        req = '0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL cont_drain got %h want %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        int strobes;
        logic saw;
        strobes = 0; saw = 1'b0;
        rand_inputs();
        req = 4'b1000;
        op[7:6] = 2'b11;
        drop_on_ack = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL ill_model got %h want %h", obs_v, exp_v);
            end
            strobes += int'(bank_en) + int'(bank_set) + int'(bank_clr);
            if (ack == 4'b1000 && err == 1'b1) saw = 1'b1;
        end
        vectors++;
        if (strobes != 0 || saw !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_result got strobes=%0d ack_err=%b want strobes=0 ack_err=1",
                     strobes, saw);
        end
    endtask

    task automatic test_random();
        drop_on_ack = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i] && $urandom_range(0, 1) == 0) begin
                    req[i] = 1'b0;
                end else if ((!req[i] && $urandom_range(0, 3) == 0) ||
                             (e_gnt[i] && $urandom_range(0, 1) == 0)) begin
                    // new request, or scrambling a committed one
                    req[i] = 1'b1;
                    op[2*i +: 2]    = 2'($urandom);
                    wdata[W*i +: W] = W'($urandom);
                end
            end
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL rand_model cyc %0d got %h want %h", cyc, obs_v, exp_v);
            end
            vectors++;
            if (!$onehot0(gnt) || ({1'b0, bank_en} + {1'b0, bank_set} + {1'b0, bank_clr}) > 2'd1) begin
                miscompares++;
                $display("FAIL rand_exclusive got gnt=%b en/set/clr=%b%b%b want one-hot",
                         gnt, bank_en, bank_set, bank_clr);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = '0;
        drop_on_ack = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) tick();
        rand_inputs();
        req = 4'b0010;
        for (int cyc = 0; cyc < 4; cyc++) tick();
        rand_inputs();
        req = 4'b0101;
        op[5:4] = 2'b00;
        drop_on_ack = 1'b0;
        tick();
        vectors++;
        if (gnt !== 4'b0100 || bank_en !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got gnt=%b en=%b want gnt=0100 en=1", gnt, bank_en);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs_v !== '0) begin
            miscompares++;
            $display("FAIL mid_async got %h want %h", obs_v, {VW{1'b0}});
        end
        tick();
        reset = 1'b1;
        drop_on_ack = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL mid_model cyc %0d got %h want %h", cyc, obs_v, exp_v);
            end
            if (cyc == 1) begin
                vectors++;
                if (gnt !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL mid_regrant got %b want 0001", gnt);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_load();
        test_set_clear();
        test_contention();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
